// File: rtl/rvh_l1d_snp_resp.sv
// rvh_l1d_snp_resp: snoop responder for one L1D bank.
// Looks up the MESI state of the snooped line and downgrades it to S or
// invalidates it through the LST snoop write port. A dirty line is first
// read from the data RAM so it can be returned with the response. The
// snoop never writes in a cycle where the s0 request path writes the LST.
// A same-line s0 write sends the FSM back to LOOKUP to re-read the state.
// Optional feature macro: RVH_L1D_SNP_CLEAN_FWD_EN. When it is defined,
// lines found in E are also read and forwarded with the response.
module rvh_l1d_snp_resp #(
   parameter int LINE_WIDTH = 512,
   parameter int SET_IDX_W  = 2,
   parameter int WAY_NUM    = 4,
   parameter int WAY_IDX_W  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   // snoop request
   input  logic                  snp_req_valid,
   output logic                  snp_req_ready,
   input  logic                  snp_req_type,
   input  logic [SET_IDX_W-1:0]  snp_req_set_idx,
   input  logic [WAY_IDX_W-1:0]  snp_req_way_idx,
   // LST read
   output logic [SET_IDX_W-1:0]  lst_rd_idx_snp,
   input  logic [2*WAY_NUM-1:0]  lst_rd_dat_snp,
   // LST snoop write
   output logic                  lst_mesi_wr_en_snp,
   output logic [SET_IDX_W-1:0]  lst_mesi_wr_set_idx_snp,
   output logic [WAY_IDX_W-1:0]  lst_mesi_wr_way_idx_snp,
   output logic [1:0]            lst_mesi_wr_dat_snp,
   // s0 LST write, watched for conflicts
   input  logic                  lst_mesi_wr_en_s0_req,
   input  logic [SET_IDX_W-1:0]  lst_mesi_wr_set_idx_s0_req,
   input  logic [WAY_IDX_W-1:0]  lst_mesi_wr_way_idx_s0_req,
   // MLFB refill pending on the snooped line
   input  logic                  mlfb_conflict,
   // data RAM read
   output logic                  dat_rd_req_valid,
   input  logic                  dat_rd_req_ready,
   output logic [SET_IDX_W-1:0]  dat_rd_set_idx,
   output logic [WAY_IDX_W-1:0]  dat_rd_way_idx,
   input  logic                  dat_rd_resp_valid,
   input  logic [LINE_WIDTH-1:0] dat_rd_resp_data,
   // snoop response
   output logic                  snp_resp_valid,
   input  logic                  snp_resp_ready,
   output logic                  snp_resp_retry,
   output logic [1:0]            snp_resp_prev_state,
   output logic                  snp_resp_has_data,
   output logic [LINE_WIDTH-1:0] snp_resp_data
);

   localparam logic [1:0] MESI_I = 2'd0;
   localparam logic [1:0] MESI_S = 2'd1;
   localparam logic [1:0] MESI_E = 2'd2;
   localparam logic [1:0] MESI_M = 2'd3;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOOKUP = 3'd1,
      ST_DATA   = 3'd2,
      ST_UPD    = 3'd3,
      ST_RESP   = 3'd4
   } state_t;

   state_t                 state_q, state_d;
   logic                   type_q, type_d;          // 1 = invalidate
   logic [SET_IDX_W-1:0]   set_q, set_d;
   logic [WAY_IDX_W-1:0]   way_q, way_d;
   logic [1:0]             prev_q, prev_d;          // state seen at the latest lookup
   logic                   retry_q, retry_d;
   logic                   has_data_q, has_data_d;
   logic [LINE_WIDTH-1:0]  data_q, data_d;
   logic                   rd_sent_q, rd_sent_d;    // data RAM request already accepted

   // Per-way view of the LST read data.
   logic [1:0] way_mesi [WAY_NUM];
   generate
      for (genvar gi = 0; gi < WAY_NUM; gi++) begin : g_way
         assign way_mesi[gi] = lst_rd_dat_snp[2*gi +: 2];
      end
   endgenerate

   logic [1:0] lookup_mesi;
   logic       lookup_needs_data;
   logic       lookup_no_write;
   logic       s0_hit;

   assign lookup_mesi = way_mesi[way_q];

`ifdef RVH_L1D_SNP_CLEAN_FWD_EN
   // Clean forward: E lines are read and returned as well as dirty ones.
   assign lookup_needs_data = (lookup_mesi == MESI_M) || (lookup_mesi == MESI_E);
`else
   // Only dirty lines need their data returned.
   assign lookup_needs_data = (lookup_mesi == MESI_M);
`endif

   // Already invalid, or already shared under a downgrade: nothing to write.
   assign lookup_no_write = (lookup_mesi == MESI_I) || ((lookup_mesi == MESI_S) && !type_q);

   // An s0 write to exactly our line makes the captured state stale.
   assign s0_hit = lst_mesi_wr_en_s0_req
                   && (lst_mesi_wr_set_idx_s0_req == set_q)
                   && (lst_mesi_wr_way_idx_s0_req == way_q);

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         type_q     <= 1'b0;
         set_q      <= '0;
         way_q      <= '0;
         prev_q     <= MESI_I;
         retry_q    <= 1'b0;
         has_data_q <= 1'b0;
         data_q     <= '0;
         rd_sent_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         type_q     <= type_d;
         set_q      <= set_d;
         way_q      <= way_d;
         prev_q     <= prev_d;
         retry_q    <= retry_d;
         has_data_q <= has_data_d;
         data_q     <= data_d;
         rd_sent_q  <= rd_sent_d;
      end
   end

   // Next-state logic for the snoop FSM.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (snp_req_valid) state_d = ST_LOOKUP;
         end
         ST_LOOKUP: begin
            if (mlfb_conflict)          state_d = ST_RESP;
            else if (lookup_no_write)   state_d = ST_RESP;
            else if (lookup_needs_data) state_d = ST_DATA;
            else                        state_d = ST_UPD;
         end
         ST_DATA: begin
            if (rd_sent_q && dat_rd_resp_valid) state_d = ST_UPD;
         end
         ST_UPD: begin
            // s0 owns the LST write port this cycle; re-read if it touched our line.
            if (lst_mesi_wr_en_s0_req) begin
               if (s0_hit) state_d = ST_LOOKUP;
            end else begin
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (snp_resp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Captures request fields, lookup result and returned line data.
   always_comb begin
      type_d     = type_q;
      set_d      = set_q;
      way_d      = way_q;
      prev_d     = prev_q;
      retry_d    = retry_q;
      has_data_d = has_data_q;
      data_d     = data_q;
      rd_sent_d  = rd_sent_q;
      case (state_q)
         ST_IDLE: begin
            if (snp_req_valid) begin
               type_d = snp_req_type;
               set_d  = snp_req_set_idx;
               way_d  = snp_req_way_idx;
            end
         end
         ST_LOOKUP: begin
            prev_d     = lookup_mesi;
            retry_d    = mlfb_conflict;
            has_data_d = !mlfb_conflict && lookup_needs_data;
            data_d     = '0;
            rd_sent_d  = 1'b0;
         end
         ST_DATA: begin
            if (!rd_sent_q && dat_rd_req_ready) rd_sent_d = 1'b1;
            if (rd_sent_q && dat_rd_resp_valid) begin
               data_d    = dat_rd_resp_data;
               rd_sent_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   // Output decode; every output is quiet outside the state that owns it.
   always_comb begin
      snp_req_ready           = (state_q == ST_IDLE) && !rst;
      lst_rd_idx_snp          = (state_q == ST_LOOKUP) ? set_q : '0;
      lst_mesi_wr_en_snp      = (state_q == ST_UPD) && !lst_mesi_wr_en_s0_req;
      lst_mesi_wr_set_idx_snp = (state_q == ST_UPD) ? set_q : '0;
      lst_mesi_wr_way_idx_snp = (state_q == ST_UPD) ? way_q : '0;
      lst_mesi_wr_dat_snp     = MESI_I;
      if ((state_q == ST_UPD) && !type_q) lst_mesi_wr_dat_snp = MESI_S;
      dat_rd_req_valid        = (state_q == ST_DATA) && !rd_sent_q;
      dat_rd_set_idx          = (state_q == ST_DATA) ? set_q : '0;
      dat_rd_way_idx          = (state_q == ST_DATA) ? way_q : '0;
      snp_resp_valid          = (state_q == ST_RESP);
      snp_resp_retry          = (state_q == ST_RESP) && retry_q;
      snp_resp_prev_state     = (state_q == ST_RESP) ? prev_q : MESI_I;
      snp_resp_has_data       = (state_q == ST_RESP) && has_data_q;
      snp_resp_data           = ((state_q == ST_RESP) && has_data_q) ? data_q : '0;
   end

endmodule

// File: tb/tb_rvh_l1d_snp_resp.sv
// Bench for rvh_l1d_snp_resp: an LST array and data RAM are modelled in the
// bench; each snoop's expected timing and results are predicted from the
// MESI snoop rules before it runs, then compared with what the DUT did.
module tb_rvh_l1d_snp_resp;
   localparam int LW = 512;
   localparam int SW = 2;
   localparam int WN = 4;
   localparam int WW = 2;
`ifdef RVH_L1D_SNP_CLEAN_FWD_EN
   localparam bit CLEAN = 1'b1;
`else
   localparam bit CLEAN = 1'b0;
`endif

   logic          clk;
   logic          rst;
   logic          snp_req_valid, snp_req_ready, snp_req_type;
   logic [SW-1:0] snp_req_set_idx;
   logic [WW-1:0] snp_req_way_idx;
   logic [SW-1:0] lst_rd_idx_snp;
   logic [2*WN-1:0] lst_rd_dat_snp;
   logic          lst_mesi_wr_en_snp;
   logic [SW-1:0] lst_mesi_wr_set_idx_snp;
   logic [WW-1:0] lst_mesi_wr_way_idx_snp;
   logic [1:0]    lst_mesi_wr_dat_snp;
   logic          lst_mesi_wr_en_s0_req;
   logic [SW-1:0] lst_mesi_wr_set_idx_s0_req;
   logic [WW-1:0] lst_mesi_wr_way_idx_s0_req;
   logic          mlfb_conflict;
   logic          dat_rd_req_valid, dat_rd_req_ready;
   logic [SW-1:0] dat_rd_set_idx;
   logic [WW-1:0] dat_rd_way_idx;
   logic          dat_rd_resp_valid;
   logic [LW-1:0] dat_rd_resp_data;
   logic          snp_resp_valid, snp_resp_ready, snp_resp_retry, snp_resp_has_data;
   logic [1:0]    snp_resp_prev_state;
   logic [LW-1:0] snp_resp_data;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   int snoop_id = 0;
   int cyc      = 0;

   logic [1:0]    lst   [4][4];
   logic [LW-1:0] lines [4][4];

   rvh_l1d_snp_resp #(.LINE_WIDTH(LW), .SET_IDX_W(SW), .WAY_NUM(WN), .WAY_IDX_W(WW)) dut (
      .clk(clk), .rst(rst),
      .snp_req_valid(snp_req_valid), .snp_req_ready(snp_req_ready), .snp_req_type(snp_req_type),
      .snp_req_set_idx(snp_req_set_idx), .snp_req_way_idx(snp_req_way_idx),
      .lst_rd_idx_snp(lst_rd_idx_snp), .lst_rd_dat_snp(lst_rd_dat_snp),
      .lst_mesi_wr_en_snp(lst_mesi_wr_en_snp), .lst_mesi_wr_set_idx_snp(lst_mesi_wr_set_idx_snp),
      .lst_mesi_wr_way_idx_snp(lst_mesi_wr_way_idx_snp), .lst_mesi_wr_dat_snp(lst_mesi_wr_dat_snp),
      .lst_mesi_wr_en_s0_req(lst_mesi_wr_en_s0_req), .lst_mesi_wr_set_idx_s0_req(lst_mesi_wr_set_idx_s0_req),
      .lst_mesi_wr_way_idx_s0_req(lst_mesi_wr_way_idx_s0_req),
      .mlfb_conflict(mlfb_conflict),
      .dat_rd_req_valid(dat_rd_req_valid), .dat_rd_req_ready(dat_rd_req_ready),
      .dat_rd_set_idx(dat_rd_set_idx), .dat_rd_way_idx(dat_rd_way_idx),
      .dat_rd_resp_valid(dat_rd_resp_valid), .dat_rd_resp_data(dat_rd_resp_data),
      .snp_resp_valid(snp_resp_valid), .snp_resp_ready(snp_resp_ready), .snp_resp_retry(snp_resp_retry),
      .snp_resp_prev_state(snp_resp_prev_state), .snp_resp_has_data(snp_resp_has_data),
      .snp_resp_data(snp_resp_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Cycle index: value of cyc between two rising edges.
   always @(posedge clk) cyc <= cyc + 1;

   // Combinational LST read port served from the bench's LST array.
   always_comb begin
      lst_rd_dat_snp = '0;
      for (int w = 0; w < WN; w++) lst_rd_dat_snp[2*w +: 2] = lst[lst_rd_idx_snp][w];
   end

   task automatic chk(input string id, input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         n_fail++;
         $error("FAIL %s %s: got %0h want %0h", id, tag, obs, exp);
      end
   endtask

   // One snoop: predict, run cycle by cycle, compare.
   task automatic run_snoop(input bit inv, input int set, input int way, input bit conflict,
                            input int s0mode, input logic [1:0] s0_val, input int rd_dly,
                            input int lat, input int hold);
      int t, k, c, lkp, upd, s0_cyc, s0_way;
      int exp_resp, exp_wr_cyc, exp_reads;
      logic [1:0] s, exp_prev, exp_wr_dat;
      bit exp_retry, exp_hd, exp_wr, needs, done;
      int req_first, rsp_cyc, reads, rd_set, rd_way;
      int wr_cnt, wr_cyc, wr_set, wr_way, resp_first, acc, unstable;
      logic [1:0] wr_dat;
      logic [LW+3:0] snap;
      bit pend_snp, pend_s0;
      logic busy_rdy, idle_rdy;
      string id;

      id = $sformatf("snp%0d", snoop_id);
      snoop_id++;

      @(negedge clk);
      snp_req_valid   = 1'b1;
      snp_req_type    = inv;
      snp_req_set_idx = SW'(set);
      snp_req_way_idx = WW'(way);
      k = 0;
      while (!snp_req_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk(id, "accept", LW'(snp_req_ready), LW'(1));
      t = cyc;

      // Reference prediction from the snoop rules.
      s = lst[set][way]; lkp = t + 1; exp_reads = 0; s0_cyc = -1;
      exp_prev = 2'd0; exp_retry = 0; exp_hd = 0; exp_wr = 0;
      exp_resp = -1; exp_wr_cyc = -1; exp_wr_dat = 2'd0; upd = 0;
      s0_way = (s0mode == 2) ? (way ^ 1) : way;
      for (int pass = 0; pass < 2; pass++) begin
         exp_prev = s; exp_retry = 0; exp_hd = 0; exp_wr = 0;
         if (pass == 0 && conflict) begin
            exp_retry = 1; exp_resp = lkp + 1; break;
         end
         if (s == 2'd0 || (s == 2'd1 && !inv)) begin
            exp_resp = lkp + 1; break;
         end
         needs = (s == 2'd3) || (CLEAN && s == 2'd2);
         if (needs) begin
            exp_reads++; exp_hd = 1; upd = lkp + 2 + rd_dly + lat;
         end else begin
            upd = lkp + 1;
         end
         if (pass == 0 && s0mode == 1) begin
            s0_cyc = upd; s = s0_val; lkp = upd + 1; continue;
         end
         if (pass == 0 && s0mode == 2) begin
            s0_cyc = upd; upd++;
         end
         exp_wr = 1; exp_wr_cyc = upd; exp_wr_dat = inv ? 2'd0 : 2'd1; exp_resp = upd + 1;
         break;
      end

      req_first = -1; rsp_cyc = -1; reads = 0; rd_set = 0; rd_way = 0;
      wr_cnt = 0; wr_cyc = -1; wr_set = 0; wr_way = 0; wr_dat = 2'd0;
      resp_first = -1; acc = -1; unstable = 0; snap = '0;
      pend_snp = 0; pend_s0 = 0; busy_rdy = 1'b1; idle_rdy = 1'b0; done = 0;

      for (int it = 0; it < 300 && !done; it++) begin
         @(negedge clk);
         c = cyc;
         if (pend_snp) lst[wr_set][wr_way] = wr_dat;
         if (pend_s0) lst[set][s0_way] = s0_val;
         pend_snp = 0; pend_s0 = 0;
         snp_req_valid = 1'b0;
         if (c == t + 1) busy_rdy = snp_req_ready;
         if (acc >= 0 && c == acc + 1) begin
            idle_rdy = snp_req_ready;
            done = 1;
         end
         dat_rd_req_ready = 1'b0;
         if (dat_rd_req_valid) begin
            if (req_first < 0) req_first = c;
            if (c >= req_first + rd_dly) begin
               dat_rd_req_ready = 1'b1;
               reads++;
               rd_set = int'(dat_rd_set_idx);
               rd_way = int'(dat_rd_way_idx);
               rsp_cyc = c + lat;
               req_first = -1;
            end
         end
         dat_rd_resp_valid = (c == rsp_cyc);
         dat_rd_resp_data  = (c == rsp_cyc) ? lines[rd_set][rd_way] : {16{32'hdead_beef}};
         snp_resp_ready = 1'b0;
         if (snp_resp_valid && acc < 0) begin
            if (resp_first < 0) begin
               resp_first = c;
               snap = {snp_resp_retry, snp_resp_prev_state, snp_resp_has_data, snp_resp_data};
            end else if ({snp_resp_retry, snp_resp_prev_state, snp_resp_has_data, snp_resp_data} !== snap) begin
               unstable++;
            end
            if (c >= resp_first + hold) begin
               snp_resp_ready = 1'b1;
               acc = c;
            end
         end
         mlfb_conflict              = conflict && (c == t + 1);
         lst_mesi_wr_en_s0_req      = (c == s0_cyc);
         lst_mesi_wr_set_idx_s0_req = SW'(set);
         lst_mesi_wr_way_idx_s0_req = WW'(s0_way);
         #1;
         if (lst_mesi_wr_en_snp) begin
            wr_cnt++;
            wr_cyc = c;
            wr_set = int'(lst_mesi_wr_set_idx_snp);
            wr_way = int'(lst_mesi_wr_way_idx_snp);
            wr_dat = lst_mesi_wr_dat_snp;
            pend_snp = 1;
         end
         if (c == s0_cyc) pend_s0 = 1;
      end
      if (pend_snp) lst[wr_set][wr_way] = wr_dat;
      if (pend_s0) lst[set][s0_way] = s0_val;
      mlfb_conflict = 1'b0; lst_mesi_wr_en_s0_req = 1'b0;
      snp_resp_ready = 1'b0; dat_rd_req_ready = 1'b0; dat_rd_resp_valid = 1'b0;

      chk(id, "completed", LW'(done), LW'(1));
      chk(id, "resp_latency", LW'(resp_first - t), LW'(exp_resp - t));
      chk(id, "prev_state", LW'(snap[LW+2:LW+1]), LW'(exp_prev));
      chk(id, "retry", LW'(snap[LW+3]), LW'(exp_retry));
      chk(id, "has_data", LW'(snap[LW]), LW'(exp_hd));
      chk(id, "data", snap[LW-1:0], exp_hd ? lines[set][way] : '0);
      chk(id, "wr_count", LW'(wr_cnt), LW'(exp_wr ? 1 : 0));
      if (exp_wr) begin
         chk(id, "wr_latency", LW'(wr_cyc - t), LW'(exp_wr_cyc - t));
         chk(id, "wr_dat", LW'(wr_dat), LW'(exp_wr_dat));
         chk(id, "wr_addr", LW'({wr_set[1:0], wr_way[1:0]}), LW'({set[1:0], way[1:0]}));
      end
      chk(id, "rd_count", LW'(reads), LW'(exp_reads));
      if (reads > 0) chk(id, "rd_addr", LW'({rd_set[1:0], rd_way[1:0]}), LW'({set[1:0], way[1:0]}));
      chk(id, "resp_stable", LW'(unstable), LW'(0));
      chk(id, "busy_not_ready", LW'(busy_rdy), LW'(0));
      chk(id, "ready_after_resp", LW'(idle_rdy), LW'(1));
      $display("%s type=%0d set=%0d way=%0d conflict=%0d s0=%0d prev=%0d retry=%0d has_data=%0d lat=%0d writes=%0d reads=%0d",
               id, inv, set, way, conflict, s0mode, snap[LW+2:LW+1], snap[LW+3], snap[LW],
               resp_first - t, wr_cnt, reads);
   endtask

   initial begin
      int t, k, cnt;
      int r, s0mode;
      rst = 1'b1;
      snp_req_valid = 1'b0; snp_req_type = 1'b0; snp_req_set_idx = '0; snp_req_way_idx = '0;
      lst_mesi_wr_en_s0_req = 1'b0; lst_mesi_wr_set_idx_s0_req = '0; lst_mesi_wr_way_idx_s0_req = '0;
      mlfb_conflict = 1'b0; dat_rd_req_ready = 1'b0; dat_rd_resp_valid = 1'b0; dat_rd_resp_data = '0;
      snp_resp_ready = 1'b0;
      for (int s = 0; s < 4; s++) begin
         for (int w = 0; w < 4; w++) begin
            lst[s][w] = 2'($urandom_range(3, 0));
            for (int j = 0; j < 16; j++) lines[s][w][32*j +: 32] = $urandom;
         end
      end

      // Reset state.
      repeat (3) @(negedge clk);
      chk("reset", "ready_in_rst", LW'(snp_req_ready), LW'(0));
      rst = 1'b0;
      #1;
      chk("reset", "ready_after", LW'(snp_req_ready), LW'(1));
      chk("reset", "outputs_quiet",
          LW'({snp_resp_valid, snp_resp_retry, snp_resp_has_data, snp_resp_prev_state,
               lst_mesi_wr_en_snp, dat_rd_req_valid, lst_rd_idx_snp}), LW'(0));
      chk("reset", "resp_data", snp_resp_data, '0);

      // Directed cases.
      lst[0][1] = 2'd3; run_snoop(1'b1, 0, 1, 1'b0, 0, 2'd0, 0, 2, 0);   // M, invalidate
      lst[2][3] = 2'd2; run_snoop(1'b0, 2, 3, 1'b0, 0, 2'd0, 0, 1, 0);   // E, downgrade
      lst[3][0] = 2'd0; run_snoop(1'b1, 3, 0, 1'b0, 0, 2'd0, 0, 1, 0);   // I
      lst[1][1] = 2'd2; run_snoop(1'b1, 1, 1, 1'b0, 1, 2'd1, 0, 1, 0);   // s0 same line
      lst[1][0] = 2'd1; run_snoop(1'b1, 1, 0, 1'b0, 2, 2'd3, 0, 1, 0);   // s0 other way
      lst[2][2] = 2'd3; run_snoop(1'b1, 2, 2, 1'b1, 0, 2'd0, 0, 1, 5);   // MLFB conflict, slow ready
      lst[0][0] = 2'd3; run_snoop(1'b0, 0, 0, 1'b0, 1, 2'd3, 1, 3, 2);   // M re-read as M

      // Stray read data while idle must be ignored.
      @(negedge clk);
      dat_rd_resp_valid = 1'b1;
      dat_rd_resp_data  = {16{32'h1234_5678}};
      @(negedge clk);
      dat_rd_resp_valid = 1'b0;
      lst[3][3] = 2'd0; run_snoop(1'b0, 3, 3, 1'b0, 0, 2'd0, 0, 1, 0);

      // Reset while waiting for the data RAM aborts silently.
      lst[1][2] = 2'd3;
      @(negedge clk);
      snp_req_valid = 1'b1; snp_req_type = 1'b1; snp_req_set_idx = 2'd1; snp_req_way_idx = 2'd2;
      k = 0;
      while (!snp_req_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      t = cyc;
      @(negedge clk);
      snp_req_valid = 1'b0;
      @(negedge clk);
      chk("abort", "rd_req", LW'(dat_rd_req_valid), LW'(1));
      @(negedge clk);
      rst = 1'b1;
      cnt = 0;
      repeat (2) begin
         @(negedge clk);
         if (lst_mesi_wr_en_snp || snp_resp_valid) cnt++;
      end
      rst = 1'b0;
      #1;
      chk("abort", "ready_after", LW'(snp_req_ready), LW'(1));
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         dat_rd_resp_valid = (i == 0);
         #1;
         if (lst_mesi_wr_en_snp || snp_resp_valid || dat_rd_req_valid) cnt++;
      end
      dat_rd_resp_valid = 1'b0;
      chk("abort", "no_activity", LW'(cnt), LW'(0));
      chk("abort", "lst_kept", LW'(lst[1][2]), LW'(2'd3));
      $display("abort start=%0d activity=%0d", t, cnt);

      // Randomized snoops.
      for (int n = 0; n < 40; n++) begin
         int set, way;
         set = $urandom_range(3, 0);
         way = $urandom_range(3, 0);
         lst[set][way] = 2'($urandom_range(3, 0));
         r = $urandom_range(4, 0);
         s0mode = (r == 3) ? 1 : ((r == 4) ? 2 : 0);
         run_snoop(1'($urandom_range(1, 0)), set, way, ($urandom_range(5, 0) == 0), s0mode,
                   2'($urandom_range(3, 0)), $urandom_range(2, 0), $urandom_range(3, 1),
                   $urandom_range(2, 0));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/rvh_l1d_snp_resp.md
# rvh_l1d_snp_resp

Snoop responder for the L1D bank. Accepts coherence snoops from the NoC, reads the line state table (LST) for the target set, computes the next MESI state, writes it back through the LST snoop write port (`lst_mesi_wr_*_snp`), fetches the line from the data RAM when it is dirty, and returns a snoop response. It owns the snoop-side writer of the LST protocol. The request side (s0) and the MLFB own the other writers.

## Interface
Parameters:
- `LINE_WIDTH`, 512: cache line width in bits.
- `SET_IDX_W`, 2: set index width, equal to the bank set index width.
- `WAY_NUM`, 4: ways per set.
- `WAY_IDX_W`, 2: way index width, `$clog2(WAY_NUM)`.

Ports:
- `clk` in 1: the only clock.
- `rst` in 1: synchronous, active-high reset.
- `snp_req_valid` / `snp_req_ready` in / out 1: snoop request handshake.
- `snp_req_type` in 1: 0 = SNP_SHARED (downgrade), 1 = SNP_INV (invalidate).
- `snp_req_set_idx` / `snp_req_way_idx` in `SET_IDX_W` / `WAY_IDX_W`: target line, already resolved by the directory.
- `lst_rd_idx_snp` out `SET_IDX_W`: LST read set index.
- `lst_rd_dat_snp` in `2*WAY_NUM`: MESI state of every way in the set; combinational, same cycle.
- `lst_mesi_wr_en_snp`, `lst_mesi_wr_set_idx_snp`, `lst_mesi_wr_way_idx_snp`, `lst_mesi_wr_dat_snp` out 1 / `SET_IDX_W` / `WAY_IDX_W` / 2: LST snoop write.
- `lst_mesi_wr_en_s0_req`, `lst_mesi_wr_set_idx_s0_req`, `lst_mesi_wr_way_idx_s0_req` in 1 / `SET_IDX_W` / `WAY_IDX_W`: s0 LST write, monitored for conflicts.
- `mlfb_conflict` in 1: the MLFB holds a refill to the snooped set/way.
- `dat_rd_req_valid` / `dat_rd_req_ready` out / in 1: data RAM read handshake.
- `dat_rd_set_idx` / `dat_rd_way_idx` out: data RAM read address.
- `dat_rd_resp_valid` in 1, `dat_rd_resp_data` in `LINE_WIDTH`: read data return.
- `snp_resp_valid` / `snp_resp_ready` out / in 1: response handshake.
- `snp_resp_retry` out 1: snoop rejected; the requester must resend.
- `snp_resp_prev_state` out 2: MESI state found at lookup.
- `snp_resp_has_data` out 1: `snp_resp_data` carries a valid line.
- `snp_resp_data` out `LINE_WIDTH`: line data.

## Operation
- MESI encoding: I = 0, S = 1, E = 2, M = 3.
- FSM states: IDLE, LOOKUP, DATA, UPD, RESP.
- `snp_req_ready` = (state == IDLE).
- IDLE: a handshake registers type, set and way, then moves to LOOKUP.
- LOOKUP: drives `lst_rd_idx_snp` = set, captures the way's 2-bit state, then branches:
  - `mlfb_conflict` → RESP with retry = 1.
  - State I, or S with SNP_SHARED → RESP, no write.
  - S/E with SNP_INV, or E with SNP_SHARED → UPD.
  - M → DATA.
- DATA: holds `dat_rd_req_valid` until `dat_rd_req_ready`, then waits for `dat_rd_resp_valid`, captures the data, and moves to UPD.
- UPD next state: SNP_SHARED → S; SNP_INV → I.
  - Asserts `lst_mesi_wr_en_snp` for exactly one cycle, unless `lst_mesi_wr_en_s0_req` is high.
  - s0 write in the same cycle: no snoop write. The LST write-data mux favours s0, so the snoop write is unsafe in any s0-write cycle.
  - If that s0 write hits the same set and way → back to LOOKUP (re-read state).
  - Otherwise → stay in UPD and retry next cycle.
  - Successful write → RESP.
- RESP: holds all `snp_resp_*` stable until `snp_resp_ready`, then returns to IDLE.
- `snp_resp_has_data` = 1 only for prev state M (see Configuration). `snp_resp_data` = 0 when has_data = 0.

## Timing
- Reset values: `snp_req_ready` 0 while `rst` is high, 1 the first cycle after. All other outputs 0; state IDLE.
- Accept at cycle T → LOOKUP at T+1.
- No-update path: response valid at T+2.
- Update path without conflict: LST write at T+2, response valid at T+3.
- M path: read request at T+2; with data at D, write at D+1 and response at D+2.
- Response accepted at R → ready again at R+1, so at most one snoop is in flight.
- `rst` mid-operation aborts with no LST write and no response. A `dat_rd_resp_valid` arriving in IDLE is ignored.
- A stalled UPD keeps the write address and data stable.

## Configuration
- `RVH_L1D_SNP_CLEAN_FWD_EN` defined: prev state E also goes through DATA and returns the line with has_data = 1 (clean forward).
- Undefined: E responds without data, and only M reads the data RAM.

## Test plan
- Line in M, SNP_INV, `dat_rd_resp` 2 cycles after the request → LST write of I, response prev = 3, has_data = 1, data matches.
- Line in E, SNP_SHARED → write S at T+2, response prev = 2 at T+3, has_data = 0 (1 with the macro, via DATA).
- Line in I → no LST write, response prev = 0 at T+2.
- s0 write to the same set/way during UPD → no snoop write that cycle, state re-read, final write uses the new state.
- s0 write to a different way during UPD → snoop write delayed exactly one cycle.
- `mlfb_conflict` at LOOKUP → retry = 1, no write, no data read. Then `snp_resp_ready` held low for 5 cycles → response stable throughout.
